// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register owner and multiply/divide sequencer for the execute stage.
// Runs a registered multiply or a restoring divide and commits the result to HI/LO.
module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;       // multiplicand, or dividend/quotient shift register
    logic [WIDTH-1:0]   b_q, b_d;       // multiplier, or divisor magnitude
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               signed_q, signed_d;
    logic               div_q, div_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               wr_q, wr_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               op_signed;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     shifted, diff;
    logic               fits;
    logic [2*WIDTH-1:0] mul_a, mul_b, product;
    logic [WIDTH-1:0]   quo_fix, rem_fix, commit_hi, commit_lo;

    assign op_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign a_abs     = (op_signed && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_abs     = (op_signed && b_i[WIDTH-1]) ? -b_i : b_i;

    // One restoring step: shift the next dividend bit in, keep the difference if it fits.
    assign shifted = {rem_q, a_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, b_q};
    assign fits    = ~diff[WIDTH];

    assign mul_a   = signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign mul_b   = signed_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign product = mul_a * mul_b;

    assign quo_fix   = q_neg_q ? -a_q : a_q;
    assign rem_fix   = r_neg_q ? -rem_q : rem_q;
    assign commit_hi = div_q ? rem_fix : res_q[2*WIDTH-1:WIDTH];
    assign commit_lo = div_q ? quo_fix : res_q[WIDTH-1:0];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        signed_d = signed_q;
        div_d    = div_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        wr_d     = wr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        stall_o  = 1'b0;
        done_o   = 1'b0;

        if (resetn && !flush_i) begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        case (op_i)
                            OP_MULT, OP_MULTU: begin
                                stall_o  = 1'b1;
                                a_d      = a_i;
                                b_d      = b_i;
                                signed_d = op_signed;
                                div_d    = 1'b0;
                                wr_d     = 1'b1;
                                state_d  = S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                stall_o  = 1'b1;
                                signed_d = op_signed;
                                div_d    = 1'b1;
                                if (b_i == '0) begin
                                    wr_d    = 1'b0;
                                    state_d = S_DONE;
                                end else begin
                                    wr_d    = 1'b1;
                                    a_d     = a_abs;
                                    b_d     = b_abs;
                                    rem_d   = '0;
                                    cnt_d   = '0;
                                    q_neg_d = op_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                                    r_neg_d = op_signed && a_i[WIDTH-1];
                                    state_d = S_DIV;
                                end
                            end
                            OP_MTHI: hi_d = a_i;
                            OP_MTLO: lo_d = a_i;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    stall_o = 1'b1;
                    res_d   = product;
                    state_d = S_DONE;
                end
                S_DIV: begin
                    stall_o = 1'b1;
                    rem_d   = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    a_d     = {a_q[WIDTH-2:0], fits};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
                end
                S_DONE: begin
                    done_o  = 1'b1;
                    state_d = S_IDLE;
                    if (wr_q) begin
                        hi_d = commit_hi;
                        lo_d = commit_lo;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            signed_q <= 1'b0;
            div_q    <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            wr_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            signed_q <= signed_d;
            div_q    <= div_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            wr_q     <= wr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Sequencer for the multiply/divide resource and owner of the architectural HI/LO registers. It sits beside the execute-stage ALU and serves MULT/MULTU, DIV/DIVU and MTHI/MTLO. It runs a single-cycle registered multiply or a 32-iteration restoring divide, and writes the result into HI/LO. It holds the pipeline with `stall_o` until the result is committed, and aborts cleanly on a pipeline flush.

## Interface
Parameters:
- `WIDTH`, 32, operand width; the divide runs WIDTH iterations.

Ports:
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  reset, synchronous and active-low.
- `start_i`  in  1  an E-stage instruction with a valid `op_i` is present.
- `op_i`  in  3  0=NONE, 1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO, 7=NONE.
- `a_i`  in  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO source).
- `b_i`  in  WIDTH  rt operand (divisor / multiplier).
- `flush_i`  in  1  exception/flush: abort the current operation.
- `stall_o`  out  1  combinational hold request to the pipeline.
- `done_o`  out  1  one-cycle pulse in the commit cycle.
- `hi_o`  out  WIDTH  current HI register (source for MFHI).
- `lo_o`  out  WIDTH  current LO register (source for MFLO).

## Operation
- **States:** IDLE, MUL, DIV, DONE.
- **Reset (resetn=0 at an edge):**
  - state = IDLE; HI = LO = 0; internal registers cleared.
  - `stall_o` = 0 and `done_o` = 0 while resetn is low.
- **Start acceptance:**
  - Operands are latched only on a start in IDLE.
  - MTHI/MTLO: HI (or LO) is written with `a_i` at that edge; the state stays IDLE; no stall.
  - MULT/MULTU: latch the operands and go to MUL.
  - DIV/DIVU with b_i ≠ 0: latch the operands and go to DIV.
  - DIV/DIVU with b_i = 0: go directly to DONE. HI/LO are left unchanged (result is architecturally undefined).
  - NONE: no action.
- **MUL state:**
  - Compute the 2·WIDTH product (signed for MULT, unsigned for MULTU) into a result register.
  - Go to DONE.
- **DIV state:**
  - Signed DIV divides absolute values as unsigned.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Restoring divide, one quotient bit per cycle. An iteration counter runs 0..WIDTH-1, and the state moves to DONE after the WIDTH-th iteration.
- **DONE state:**
  - `done_o` = 1.
  - At the exiting edge: HI = {product[63:32] or remainder}, LO = {product[31:0] or quotient}.
  - Next state is IDLE. `start_i` is ignored in DONE, because the held instruction is still presented that cycle and must not restart.
- **stall_o:**
  - Equals 1 in IDLE when start_i is high and op is MULT/MULTU/DIV/DIVU.
  - Equals 1 in MUL and DIV.
  - Equals 0 in DONE and in all other cases.
- **Flush:**
  - flush_i = 1 forces `stall_o` = 0 and `done_o` = 0 combinationally.
  - Next state is IDLE; HI/LO are not written.
  - A start presented in the same cycle as a flush is ignored, including MTHI/MTLO.
- **Busy period:** the pipeline holds `op_i`, `a_i` and `b_i` stable while `stall_o` = 1. The block nevertheless works only from its latched copies.

## Timing
- Cycle 0 is the cycle in which start is presented in IDLE.
- **MULT/MULTU:**
  - Cycle 0 IDLE, stall=1; cycle 1 MUL, stall=1; cycle 2 DONE, stall=0, done=1.
  - New HI/LO are visible on `hi_o`/`lo_o` from cycle 3.
- **DIV/DIVU:**
  - Cycle 0 IDLE, stall=1; cycles 1..32 DIV, stall=1; cycle 33 DONE, stall=0.
  - HI/LO are visible from cycle 34.
- **Divide by zero:** cycle 0 stall=1; cycle 1 DONE.
- **MTHI/MTLO:** value is visible from cycle 1.
- **Back-to-back:** a new start is accepted no earlier than the cycle after DONE, i.e. in IDLE again.
- **Forwarding:** `hi_o`/`lo_o` are registered outputs only. There is no bypass of a same-cycle MTHI/MTLO or commit; hazard handling belongs to the pipeline.

## Test plan
- **MULT:** a=0xFFFFFFFE (−2), b=3 → stall high for 2 cycles, done in cycle 2, HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- **DIV:** a=−7, b=2 → stall high for 33 cycles, done in cycle 33, LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU a=7, b=2 → LO=3, HI=1.
- **Signed overflow:** DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0. DIVU a=5, b=0 → stall for 1 cycle only, HI/LO unchanged.
- **Move to HI/LO:** MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles → no stall; hi_o/lo_o update one cycle after each.
- **Flush mid-operation:** flush_i asserted in cycle 10 of a DIV → stall_o=0 that cycle, IDLE next cycle, HI/LO keep their old values; a following MULT completes normally.
- **Reset mid-operation:** resetn pulled low during MUL or DIV → next cycle state IDLE, HI=LO=0, stall_o=0. Also check that start held high through DONE does not re-trigger.
